// File: rtl/word_tx_arbiter.sv
// Two-requester round-robin arbiter that serializes whole words LSB-first onto a
// byte-wide valid/ready sink; a granted word is fully sent before re-arbitration.
module word_tx_arbiter #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [8*BYTES-1:0] req0_word,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [8*BYTES-1:0] req1_word,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic               grant_id
);

  localparam int W  = 8 * BYTES;
  localparam int CW = $clog2(BYTES) + 1;

  typedef enum logic {IDLE, SEND} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic           pick0, pick1;

  // Arbitration: a tie goes to whichever requester was not served last.
  always_comb begin
    pick0 = 1'b0;
    pick1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        pick0 = last_q;
        pick1 = !last_q;
      end else begin
        pick0 = req0_valid;
        pick1 = req1_valid;
      end
    end
  end

  assign req0_ready = pick0;
  assign req1_ready = pick1;
  assign busy       = (state_q == SEND);
  assign grant_id   = grant_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    last_d   = last_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (pick0) begin
          shift_d = req0_word;
          grant_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
          state_d = SEND;
        end else if (pick1) begin
          shift_d = req1_word;
          grant_d = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift_q[7:0];
        // The shift register holds still under backpressure, so tx_data stays stable.
        if (tx_ready) begin
          shift_d = shift_q >> 8;
          if (cnt_q == CW'(BYTES - 1)) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_word_tx_arbiter.sv
// Directed bench for word_tx_arbiter: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_word_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_word, req1_word;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        busy, grant_id;

  int checks   = 0;
  int failures = 0;

  word_tx_arbiter #(.BYTES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_word  (req0_word),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_word  (req1_word),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Leaves the bench just after a falling edge, DUT in IDLE, reset released.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; tx_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; tx_ready = 1'b0;
    req0_word = 32'h1111_1111; req1_word = 32'h2222_2222;
    @(negedge clk); #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++;
      $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if ({tx_valid, busy, grant_id} !== 3'b000) begin failures++;
      $display("FAIL reset_flags got=%b exp=000", {tx_valid, busy, grant_id}); end
    checks++; if (tx_data !== 8'h00) begin failures++;
      $display("FAIL reset_data got=%h exp=00", tx_data); end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4] = '{8'h67, 8'h45, 8'h23, 8'h01};
    do_reset();
    req0_valid = 1'b1; req0_word = 32'h0123_4567; tx_ready = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++;
      $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checks++; if ({tx_valid, busy, grant_id, tx_data} !== {3'b110, exp[k]}) begin failures++;
        $display("FAIL single_byte%0d got v/b/g/d=%b%b%b/%h exp=110/%h", k, tx_valid, busy, grant_id, tx_data, exp[k]); end
    end
    @(negedge clk); #1;
    checks++; if ({tx_valid, busy} !== 2'b00) begin failures++;
      $display("FAIL single_idle got=%b exp=00", {tx_valid, busy}); end
  endtask

  task automatic test_tie();
    do_reset();
    req0_valid = 1'b1; req0_word = 32'hAAAA_AAAA;
    req1_valid = 1'b1; req1_word = 32'h5555_5555;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++;
      $display("FAIL tie_first got=%b exp=10", {req0_ready, req1_ready}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checks++; if ({tx_valid, grant_id, req1_ready, tx_data} !== {3'b100, 8'hAA}) begin failures++;
        $display("FAIL tie_a%0d got v/g/r1/d=%b%b%b/%h exp=100/aa", k, tx_valid, grant_id, req1_ready, tx_data); end
    end
    @(negedge clk); #1;
    checks++; if ({tx_valid, req0_ready, req1_ready} !== 3'b001) begin failures++;
      $display("FAIL tie_gap got v/r0/r1=%b exp=001", {tx_valid, req0_ready, req1_ready}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++; if ({tx_valid, grant_id, tx_data} !== {2'b11, 8'h55}) begin failures++;
        $display("FAIL tie_b%0d got v/g/d=%b%b/%h exp=11/55", k, tx_valid, grant_id, tx_data); end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] b0 [4] = '{8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [7:0] b1 [4] = '{8'hB3, 8'hB2, 8'hB1, 8'hB0};
    logic       exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] e;
    do_reset();
    req0_valid = 1'b1; req0_word = 32'hA0A1_A2A3;
    req1_valid = 1'b1; req1_word = 32'hB0B1_B2B3;
    for (int w = 0; w < 4; w++) begin
      #1;
      checks++; if ({req0_ready, req1_ready} !== {!exp_g[w], exp_g[w]}) begin failures++;
        $display("FAIL rr_ready%0d got=%b exp=%b", w, {req0_ready, req1_ready}, {!exp_g[w], exp_g[w]}); end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk); #1;
        e = exp_g[w] ? b1[k] : b0[k];
        checks++; if ({tx_valid, grant_id, tx_data} !== {1'b1, exp_g[w], e}) begin failures++;
          $display("FAIL rr_w%0d_b%0d got v/g/d=%b%b/%h exp=1%b/%h", w, k, tx_valid, grant_id, tx_data, exp_g[w], e); end
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic       rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] exp [7] = '{8'h11, 8'h22, 8'h33, 8'h33, 8'h33, 8'h33, 8'h44};
    do_reset();
    req0_valid = 1'b1; req0_word = 32'h4433_2211;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++;
      $display("FAIL bp_accept got=%b exp=1", req0_ready); end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req0_valid = 1'b0; tx_ready = rdy[c];
      #1;
      checks++; if ({tx_valid, tx_data} !== {1'b1, exp[c]}) begin failures++;
        $display("FAIL bp_cycle%0d got v/d=%b/%h exp=1/%h", c, tx_valid, tx_data, exp[c]); end
    end
    @(negedge clk); #1;
    checks++; if ({tx_valid, busy} !== 2'b00) begin failures++;
      $display("FAIL bp_end got=%b exp=00", {tx_valid, busy}); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    req0_valid = 1'b1; req0_word = 32'h0123_4567;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h23}) begin failures++;
      $display("FAIL mid_before got v/d=%b/%h exp=1/23", tx_valid, tx_data); end
    @(negedge clk); #1;
    checks++; if ({tx_valid, busy, grant_id, tx_data} !== 11'b000_00000000) begin failures++;
      $display("FAIL mid_abort got v/b/g/d=%b%b%b/%h exp=000/00", tx_valid, busy, grant_id, tx_data); end
    reset = 1'b0; req1_valid = 1'b1; req1_word = 32'hDEAD_BEEF;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++;
      $display("FAIL mid_req1 got=%b exp=01", {req0_ready, req1_ready}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++; if ({tx_valid, grant_id, tx_data} !== {2'b11, exp[k]}) begin failures++;
        $display("FAIL mid_b%0d got v/g/d=%b%b/%h exp=11/%h", k, tx_valid, grant_id, tx_data, exp[k]); end
    end
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++;
      $display("FAIL mid_tie got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
  endtask

  task automatic test_ready_in_send();
    logic [7:0] exp [4] = '{8'h0D, 8'h0C, 8'h0B, 8'h0A};
    do_reset();
    req0_valid = 1'b1; req0_word = 32'h0A0B_0C0D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b1; req1_word = 32'h1F2E_3D4C;
      #1;
      checks++; if ({req1_ready, tx_valid, tx_data} !== {2'b01, exp[k]}) begin failures++;
        $display("FAIL send_b%0d got r1/v/d=%b%b/%h exp=01/%h", k, req1_ready, tx_valid, tx_data, exp[k]); end
    end
    @(negedge clk); #1;
    checks++; if ({busy, req1_ready} !== 2'b01) begin failures++;
      $display("FAIL send_idle got b/r1=%b exp=01", {busy, req1_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++; if ({busy, grant_id, tx_data} !== {2'b11, 8'h4C}) begin failures++;
      $display("FAIL send_next got b/g/d=%b%b/%h exp=11/4c", busy, grant_id, tx_data); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid_word();
    test_ready_in_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
